// File: rtl/ram_arbiter_2port.sv
// Two-port round-robin arbiter/sequencer for a single RAM_256x32; every access takes 4 cycles.
// Define ARB_FIXED_PRIO_EN to give port 0 fixed priority over port 1.
module ram_arbiter_2port #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              REQ0,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] WDATA0,
  output logic              ACK0,
  output logic [DATA_W-1:0] RDATA0,
  input  logic              REQ1,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              ACK1,
  output logic [DATA_W-1:0] RDATA1,
  output logic [ADDR_W-1:0] RAM_Addr,
  output logic [DATA_W-1:0] RAM_DataIn,
  output logic              RAM_RW,
  input  logic [DATA_W-1:0] RAM_DataOut,
  output logic              BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_gnt;
  logic              r_op_we;
  logic              r_ack0;
  logic              r_ack1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_din;
  logic              r_ram_rw;
`ifndef ARB_FIXED_PRIO_EN
  logic              r_last_grant;
`endif

  logic              w_gnt;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // Winner selection for the IDLE edge
  always_comb begin
    w_gnt = 1'b0;
    if (REQ0 && REQ1) begin
`ifdef ARB_FIXED_PRIO_EN
      w_gnt = 1'b0;
`else
      w_gnt = ~r_last_grant;
`endif
    end else if (REQ1) begin
      w_gnt = 1'b1;
    end else begin
      w_gnt = 1'b0;
    end
  end

  // Mux the winning port's transaction fields
  always_comb begin
    w_sel_we    = WE0;
    w_sel_addr  = ADDR0;
    w_sel_wdata = WDATA0;
    if (w_gnt) begin
      w_sel_we    = WE1;
      w_sel_addr  = ADDR1;
      w_sel_wdata = WDATA1;
    end else begin
      w_sel_we    = WE0;
      w_sel_addr  = ADDR0;
      w_sel_wdata = WDATA0;
    end
  end

  // Access sequencer: IDLE -> ISSUE -> WAIT -> RESP -> IDLE
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state    <= S_IDLE;
      r_gnt      <= 1'b0;
      r_op_we    <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ram_rw   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (REQ0 || REQ1) begin
            r_ram_addr <= w_sel_addr;
            r_ram_din  <= w_sel_wdata;
            r_ram_rw   <= w_sel_we;
            r_op_we    <= w_sel_we;
            r_gnt      <= w_gnt;
`ifndef ARB_FIXED_PRIO_EN
            r_last_grant <= w_gnt;
`endif
            r_state    <= S_ISSUE;
          end else begin
            r_ram_rw <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_ISSUE: begin
          // RAM commits the write / registers read data on this edge
          r_ram_rw <= 1'b0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (r_gnt) begin
            r_ack1 <= 1'b1;
            if (!r_op_we) begin
              r_rdata1 <= RAM_DataOut;
            end else begin
              r_rdata1 <= r_rdata1;
            end
          end else begin
            r_ack0 <= 1'b1;
            if (!r_op_we) begin
              r_rdata0 <= RAM_DataOut;
            end else begin
              r_rdata0 <= r_rdata0;
            end
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ack0   <= 1'b0;
          r_ack1   <= 1'b0;
          r_ram_rw <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign ACK0       = r_ack0;
  assign ACK1       = r_ack1;
  assign RDATA0     = r_rdata0;
  assign RDATA1     = r_rdata1;
  assign RAM_Addr   = r_ram_addr;
  assign RAM_DataIn = r_ram_din;
  assign RAM_RW     = r_ram_rw;
  assign BUSY       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ram_arbiter_2port.sv
// Self-checking bench for ram_arbiter_2port with a behavioural RAM and per-port read-data scoreboards.
module tb_ram_arbiter_2port;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        REQ0 = 1'b0, WE0 = 1'b0, REQ1 = 1'b0, WE1 = 1'b0;
  logic [7:0]  ADDR0 = 8'h00, ADDR1 = 8'h00;
  logic [31:0] WDATA0 = 32'h0, WDATA1 = 32'h0;
  logic        ACK0, ACK1, RAM_RW, BUSY;
  logic [31:0] RDATA0, RDATA1, RAM_DataIn, RAM_DataOut;
  logic [7:0]  RAM_Addr;

  int checks = 0;
  int failures = 0;

  logic [31:0] ram_mem [0:255];
  logic [31:0] model_mem [0:255];
  logic [31:0] last_rd [0:1];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  ram_arbiter_2port dut (
    .CLK(CLK), .RSTn(RSTn),
    .REQ0(REQ0), .WE0(WE0), .ADDR0(ADDR0), .WDATA0(WDATA0), .ACK0(ACK0), .RDATA0(RDATA0),
    .REQ1(REQ1), .WE1(WE1), .ADDR1(ADDR1), .WDATA1(WDATA1), .ACK1(ACK1), .RDATA1(RDATA1),
    .RAM_Addr(RAM_Addr), .RAM_DataIn(RAM_DataIn), .RAM_RW(RAM_RW),
    .RAM_DataOut(RAM_DataOut), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Behavioural synchronous RAM, no reset
  always @(posedge CLK) begin
    if (RAM_RW) ram_mem[RAM_Addr] <= RAM_DataIn;
    RAM_DataOut <= ram_mem[RAM_Addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model the transaction and push the RDATA value expected at its ACK
  task automatic push_exp(input bit port, input bit we, input logic [7:0] addr, input logic [31:0] data);
    logic [31:0] e;
    if (we) begin
      model_mem[addr] = data;
      e = last_rd[port];
    end else begin
      e = model_mem[addr];
      last_rd[port] = e;
    end
    if (port) q1.push_back(e); else q0.push_back(e);
  endtask

  task automatic drive(input bit port, input bit req, input bit we, input logic [7:0] addr, input logic [31:0] data);
    if (port) begin REQ1 = req; WE1 = we; ADDR1 = addr; WDATA1 = data; end
    else      begin REQ0 = req; WE0 = we; ADDR0 = addr; WDATA0 = data; end
  endtask

  // Scoreboard: compare RDATA on every ACK, mid-cycle
  always @(negedge CLK) begin
    if (RSTn) begin
      chk("ack_overlap", {31'd0, ACK0 & ACK1}, 32'd0);
      if (ACK0) begin
        if (q0.size() > 0) chk("rdata0", RDATA0, q0.pop_front());
        else chk("ack0_spurious", {31'd0, ACK0}, 32'd0);
      end
      if (ACK1) begin
        if (q1.size() > 0) chk("rdata1", RDATA1, q1.pop_front());
        else chk("ack1_spurious", {31'd0, ACK1}, 32'd0);
      end
    end
  end

  task automatic do_reset();
    RSTn = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0;
    @(posedge CLK); #1;
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_rw", {31'd0, RAM_RW}, 32'd0);
    chk("rst_acks", {30'd0, ACK1, ACK0}, 32'd0);
    chk("rst_addr", {24'd0, RAM_Addr}, 32'd0);
    chk("rst_din", RAM_DataIn, 32'd0);
    chk("rst_rdata0", RDATA0, 32'd0);
    chk("rst_rdata1", RDATA1, 32'd0);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    RSTn = 1'b1;
  endtask

  // Single uncontended access with cycle-exact checks; called just after a posedge in IDLE
  task automatic access(input bit port, input bit we, input logic [7:0] addr, input logic [31:0] data);
    push_exp(port, we, addr, data);
    drive(port, 1'b1, we, addr, data);
    @(posedge CLK); #1;
    chk("c0_busy", {31'd0, BUSY}, 32'd1);
    chk("c0_rw", {31'd0, RAM_RW}, {31'd0, we});
    chk("c0_addr", {24'd0, RAM_Addr}, {24'd0, addr});
    if (we) chk("c0_din", RAM_DataIn, data);
    @(posedge CLK); #1;
    chk("c1_rw", {31'd0, RAM_RW}, 32'd0);
    chk("c1_acks", {30'd0, ACK1, ACK0}, 32'd0);
    @(posedge CLK); #1;
    chk("c2_acks", {30'd0, ACK1, ACK0}, port ? 32'd2 : 32'd1);
    chk("c2_busy", {31'd0, BUSY}, 32'd1);
    drive(port, 1'b0, 1'b0, 8'h00, 32'h0);
    @(posedge CLK); #1;
    chk("c3_acks", {30'd0, ACK1, ACK0}, 32'd0);
    chk("c3_busy", {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    int n0, n1, cyc, last_cyc;
    bit exp_g;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    do_reset();

    // 1-2: write then read-back through the other port
    access(1'b0, 1'b1, 8'h05, 32'hDEADBEEF);
    access(1'b1, 1'b0, 8'h05, 32'h0);
    chk("rdata0_unchanged", RDATA0, 32'd0);

    // 3: bank boundary
    access(1'b0, 1'b1, 8'h3F, 32'h11111111);
    access(1'b0, 1'b1, 8'h40, 32'h22222222);
    access(1'b1, 1'b0, 8'h3F, 32'h0);
    access(1'b0, 1'b0, 8'h40, 32'h0);
    access(1'b1, 1'b0, 8'h40, 32'h0);

    // 5: reset while a read sits in WAIT
    drive(1'b0, 1'b1, 1'b0, 8'h05, 32'h0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    do_reset();
    access(1'b0, 1'b0, 8'h3F, 32'h0);

    // 4: constant contention from reset, port 0 first
    do_reset();
    n0 = 0; n1 = 0; cyc = 0; last_cyc = -1; exp_g = 1'b0;
    push_exp(1'b0, 1'b1, 8'h10, 32'hA0000000);
    drive(1'b0, 1'b1, 1'b1, 8'h10, 32'hA0000000);
    push_exp(1'b1, 1'b1, 8'h90, 32'hB0000000);
    drive(1'b1, 1'b1, 1'b1, 8'h90, 32'hB0000000);
    for (int c = 0; c < 60 && (n0 < 3 || n1 < 3); c++) begin
      @(posedge CLK); #1;
      cyc++;
      if (ACK0 || ACK1) begin
        chk("rr_order", {31'd0, ACK1}, {31'd0, exp_g});
        if (last_cyc >= 0) chk("rr_spacing", cyc - last_cyc, 32'd4);
        else chk("rr_first_latency", cyc, 32'd3);
        last_cyc = cyc;
        exp_g = ~exp_g;
        if (ACK0) begin
          n0++;
          if (n0 < 3) begin
            push_exp(1'b0, 1'b1, 8'h10 + 8'(n0), 32'hA0000000 + 32'(n0));
            drive(1'b0, 1'b1, 1'b1, 8'h10 + 8'(n0), 32'hA0000000 + 32'(n0));
          end else drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        end
        if (ACK1) begin
          n1++;
          if (n1 < 3) begin
            push_exp(1'b1, 1'b1, 8'h90 + 8'(n1), 32'hB0000000 + 32'(n1));
            drive(1'b1, 1'b1, 1'b1, 8'h90 + 8'(n1), 32'hB0000000 + 32'(n1));
          end else drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
        end
      end
    end
    chk("rr_total", n0 + n1, 32'd6);
    @(posedge CLK); #1;
    access(1'b1, 1'b0, 8'h12, 32'h0);
    access(1'b0, 1'b0, 8'h91, 32'h0);

`ifdef ARB_FIXED_PRIO_EN
    // 6: fixed priority starves port 1 until REQ0 drops
    do_reset();
    n0 = 0; n1 = 0; cyc = 0; last_cyc = -1;
    push_exp(1'b0, 1'b0, 8'h05, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 8'h05, 32'h0);
    push_exp(1'b1, 1'b1, 8'hC0, 32'hC0FFEE00);
    drive(1'b1, 1'b1, 1'b1, 8'hC0, 32'hC0FFEE00);
    for (int c = 0; c < 60 && n1 == 0; c++) begin
      @(posedge CLK); #1;
      cyc++;
      if (ACK0) begin
        n0++;
        last_cyc = cyc;
        if (n0 < 3) push_exp(1'b0, 1'b0, 8'h05, 32'h0);
        else drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      end
      if (ACK1) begin
        n1++;
        chk("fp_acks0_before_1", n0, 32'd3);
        chk("fp_spacing", cyc - last_cyc, 32'd4);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
      end
    end
    chk("fp_port1_served", n1, 32'd1);
    @(posedge CLK); #1;
`endif

    repeat (3) @(posedge CLK);
    #1;
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
